// File: rtl/lightbar_sequencer.sv
// Lightbar pattern engine: steps an N-bit LED frame once per divider tick.
// Supported patterns are off, half-flash, single-LED bounce and progressive fill.
module lightbar_sequencer #(
  parameter int unsigned N = 8
) (
  input  logic         CLK_IN,
  input  logic         RESET,
  input  logic         TICK_IN,
  input  logic [1:0]   MODE_IN,
  input  logic         FREEZE_IN,
  output logic [N-1:0] LED_OUT,
  output logic         WRAP_OUT
);

  localparam int unsigned PW = $clog2(N);

  localparam logic [N-1:0] ONE        = N'(1);
  localparam logic [N-1:0] LOWER_HALF = {{(N/2){1'b0}}, {(N/2){1'b1}}};
  localparam logic [N-1:0] UPPER_HALF = ~LOWER_HALF;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_FLASH  = 2'd1,
    ST_BOUNCE = 2'd2,
    ST_FILL   = 2'd3
  } state_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  state_t          state_q, state_d;
  state_t          mode_sel;
  dir_t            dir_q, dir_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic [N-1:0]    led_d;
  logic            wrap_d;
  logic            step;

  assign step = TICK_IN & ~FREEZE_IN;

  // Decode the requested pattern into the state encoding.
  always_comb begin
    mode_sel = ST_OFF;
    case (MODE_IN)
      2'd0:    mode_sel = ST_OFF;
      2'd1:    mode_sel = ST_FLASH;
      2'd2:    mode_sel = ST_BOUNCE;
      default: mode_sel = ST_FILL;
    endcase
  end

  // Next-state, position, direction, frame and wrap pulse for one step.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    led_d   = LED_OUT;
    wrap_d  = 1'b0;

    if (step) begin
      if (mode_sel != state_q) begin
        // Mode change restarts the new pattern and suppresses any wrap.
        state_d = mode_sel;
        pos_d   = '0;
        dir_d   = DIR_UP;
        case (mode_sel)
          ST_OFF:    led_d = '0;
          ST_FLASH:  led_d = LOWER_HALF;
          ST_BOUNCE: led_d = ONE;
          default:   led_d = '0;
        endcase
      end else begin
        case (state_q)
          ST_OFF: begin
            led_d  = '0;
            wrap_d = 1'b1;
          end

          ST_FLASH: begin
            if (LED_OUT == LOWER_HALF) begin
              led_d = UPPER_HALF;
            end else begin
              led_d  = LOWER_HALF;
              wrap_d = 1'b1;
            end
          end

          ST_BOUNCE: begin
            // Direction flips on the edge that reaches an end, so end LEDs never repeat.
            if (dir_q == DIR_UP) begin
              pos_d = pos_q + PW'(1);
              if (pos_q == PW'(N - 2)) begin
                dir_d = DIR_DOWN;
              end
            end else begin
              pos_d = pos_q - PW'(1);
              if (pos_q == PW'(1)) begin
                dir_d  = DIR_UP;
                wrap_d = 1'b1;
              end
            end
            led_d = ONE << pos_d;
          end

          default: begin
            // pos parks at N-1 once the last LED is set; the full frame triggers the clear.
            if (LED_OUT == '1) begin
              led_d  = '0;
              pos_d  = '0;
              wrap_d = 1'b1;
            end else begin
              led_d = LED_OUT | (ONE << pos_q);
              if (pos_q != PW'(N - 1)) begin
                pos_d = pos_q + PW'(1);
              end
            end
          end
        endcase
      end
    end
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge CLK_IN or posedge RESET) begin
    if (RESET) begin
      state_q  <= ST_OFF;
      pos_q    <= '0;
      dir_q    <= DIR_UP;
      LED_OUT  <= '0;
      WRAP_OUT <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      dir_q    <= dir_d;
      LED_OUT  <= led_d;
      WRAP_OUT <= wrap_d;
    end
  end

endmodule

// File: tb/tb_lightbar_sequencer.sv
// Self-checking bench for lightbar_sequencer: directed pattern walks plus
// randomized ticks, freezes, mode changes and async resets against a model.
module tb_lightbar_sequencer;

  localparam int unsigned N = 8;

  logic         CLK_IN = 1'b0;
  logic         RESET;
  logic         TICK_IN;
  logic [1:0]   MODE_IN;
  logic         FREEZE_IN;
  logic [N-1:0] LED_OUT;
  logic         WRAP_OUT;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model: current mode plus the step index within that mode's period.
  int unsigned m_mode = 0;
  int unsigned m_k    = 0;
  logic        m_wrap = 1'b0;

  logic [7:0] bounce_exp [15] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
  logic [7:0] fill_exp   [10] = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F,
                                  8'hFF, 8'h00};
  logic [7:0] flash_exp  [4]  = '{8'h0F, 8'hF0, 8'h0F, 8'hF0};

  lightbar_sequencer #(.N(N)) dut (
    .CLK_IN    (CLK_IN),
    .RESET     (RESET),
    .TICK_IN   (TICK_IN),
    .MODE_IN   (MODE_IN),
    .FREEZE_IN (FREEZE_IN),
    .LED_OUT   (LED_OUT),
    .WRAP_OUT  (WRAP_OUT)
  );

  always #10 CLK_IN = ~CLK_IN;

  function automatic int unsigned period(input int unsigned md);
    case (md)
      0:       return 1;
      1:       return 2;
      2:       return 2 * N - 2;
      default: return N + 1;
    endcase
  endfunction

  function automatic logic [N-1:0] frame(input int unsigned md, input int unsigned k);
    logic [N-1:0] one;
    logic [N-1:0] low;
    int unsigned  p;
    one = 1;
    low = (one << (N / 2)) - 1;
    case (md)
      0:       return '0;
      1:       return (k == 0) ? low : ~low;
      2: begin
        p = (k < N) ? k : (2 * N - 2 - k);
        return one << p;
      end
      default: return (k >= N) ? '1 : ((one << k) - 1);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Applies inputs, takes one clock edge, updates the model and checks outputs.
  task automatic cycle(input logic tick, input logic freeze, input logic [1:0] mode);
    TICK_IN   = tick;
    FREEZE_IN = freeze;
    MODE_IN   = mode;
    @(posedge CLK_IN);
    m_wrap = 1'b0;
    if (tick && !freeze) begin
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode);
        m_k    = 0;
      end else begin
        m_k    = (m_k + 1) % period(m_mode);
        m_wrap = (m_k == 0);
      end
    end
    #1;
    check("led", 32'(LED_OUT), 32'(frame(m_mode, m_k)));
    check("wrap", 32'(WRAP_OUT), 32'(m_wrap));
  endtask

  // Asserts reset between clock edges and checks the clear happens with no edge.
  task automatic reset_mid;
    #4;
    RESET = 1'b1;
    #1;
    check("rst_led", 32'(LED_OUT), 32'h0);
    check("rst_wrap", 32'(WRAP_OUT), 32'h0);
    m_mode = 0;
    m_k    = 0;
    m_wrap = 1'b0;
    #2;
    RESET = 1'b0;
  endtask

  initial begin
    logic [1:0] cur_mode;
    RESET     = 1'b1;
    TICK_IN   = 1'b0;
    FREEZE_IN = 1'b0;
    MODE_IN   = 2'd0;
    repeat (2) @(posedge CLK_IN);
    #1;
    check("por_led", 32'(LED_OUT), 32'h0);
    check("por_wrap", 32'(WRAP_OUT), 32'h0);
    #5;
    RESET = 1'b0;

    // Idle with no ticks: outputs hold at reset values.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'd2);

    // Bounce walk: mode-change tick plus a full period.
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 1'b0, 2'd2);
      check("bounce_tbl", 32'(LED_OUT), 32'(bounce_exp[i]));
      check("bounce_wrap", 32'(WRAP_OUT), 32'(i == 14));
      cycle(1'b0, 1'b0, 2'd2);
    end

    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 2'd3);
      check("fill_tbl", 32'(LED_OUT), 32'(fill_exp[i]));
      check("fill_wrap", 32'(WRAP_OUT), 32'(i == 9));
    end

    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 2'd1);
      check("flash_tbl", 32'(LED_OUT), 32'(flash_exp[i]));
      check("flash_wrap", 32'(WRAP_OUT), 32'(i == 2));
    end

    // Walk bounce to 0x10, then freeze and change mode while frozen.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 2'd2);
    check("frz_pre", 32'(LED_OUT), 32'h10);
    cycle(1'b1, 1'b1, 2'd2);
    cycle(1'b1, 1'b1, 2'd3);
    cycle(1'b1, 1'b1, 2'd3);
    check("frz_hold", 32'(LED_OUT), 32'h10);
    cycle(1'b1, 1'b0, 2'd3);
    check("frz_sw_led", 32'(LED_OUT), 32'h00);
    check("frz_sw_wrap", 32'(WRAP_OUT), 32'h0);

    // Fill to 0x3F, then reset mid-pattern.
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 2'd3);
    check("fill_3f", 32'(LED_OUT), 32'h3F);
    reset_mid();

    // Held tick after reset: mode restarts from OFF, consecutive frames.
    cycle(1'b1, 1'b0, 2'd2);
    check("held0", 32'(LED_OUT), 32'h01);
    cycle(1'b1, 1'b0, 2'd2);
    check("held1", 32'(LED_OUT), 32'h02);
    cycle(1'b1, 1'b0, 2'd2);
    check("held2", 32'(LED_OUT), 32'h04);

    // OFF mode wraps on every step.
    cycle(1'b1, 1'b0, 2'd0);
    cycle(1'b1, 1'b0, 2'd0);
    check("off_wrap", 32'(WRAP_OUT), 32'h1);

    // Randomized run.
    cur_mode = 2'd0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        reset_mid();
      end else begin
        if ($urandom_range(0, 19) == 0) cur_mode = 2'($urandom_range(0, 3));
        cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 15, cur_mode);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
